button_debounce: RTL and testbench
==================================

# button_debounce

Input-side conditioner for the board's push buttons. It synchronises a raw asynchronous pin into the 48 MHz HFOSC clock domain, debounces it, and emits clean level, press, release and long-press events. Downstream LED/colour logic consumes it to step modes. It is the input counterpart of the LED output drivers.

## Interface
- `DEBOUNCE_CYCLES`, default 480000: stable-sample count required to accept a level change (10 ms at 48 MHz); legal values ≥ 2.
- `LONG_CYCLES`, default 48000000: held cycles after an accepted press before the long-press event (1 s); legal values ≥ 2.
- `ACTIVE_LOW`, default 1: 1 = pin reads 0 when pressed (pull-up wiring).
- `clk`  in  1  system clock (HFOSC).
- `rst_n`  in  1  reset; synchronous, active-low.
- `btn_in`  in  1  raw asynchronous button pin.
- `btn_level`  out  1  debounced pressed state, 1 = pressed.
- `press`  out  1  one-cycle pulse on accepted press.
- `release`  out  1  one-cycle pulse on accepted release.
- `long_press`  out  1  one-cycle pulse, at most once per press.
- `press_count`  out  8  accepted presses, modulo 256.

## Operation
- Input path: `btn_in` → 2-flop synchroniser → polarity normalise (`act` = 1 means pressed). Both synchroniser flops reset to the inactive pin level.
- One counter `cnt` is shared by debounce and hold timing. Width is `$clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES))`. It never wraps, because each state exits at its terminal value.
- Flag `long_done` is set when `long_press` fires and cleared on entry to IDLE.
- State IDLE (`btn_level`=0):
  - `act`=1 → DB_DOWN, `cnt`←0.
- State DB_DOWN (`btn_level`=0):
  - `act`=0 → IDLE. A bounce restarts qualification; no event is emitted.
  - Otherwise, while `cnt` < `DEBOUNCE_CYCLES`-1, `cnt`++.
  - At `cnt` = `DEBOUNCE_CYCLES`-1 → DOWN, `cnt`←0, `press` pulses, `press_count`++.
- State DOWN (`btn_level`=1):
  - `act`=0 → DB_UP. The hold count is saved in `held`, and `cnt`←0.
  - Otherwise `cnt`++.
  - At `cnt` = `LONG_CYCLES`-1 with `long_done`=0: `long_press` pulses, `long_done`←1, and `cnt` holds.
- State DB_UP (`btn_level`=1):
  - `act`=1 → DOWN, `cnt`←`held`. Hold timing resumes; time spent bouncing is not counted.
  - At `cnt` = `DEBOUNCE_CYCLES`-1 with `act`=0 → IDLE, `release` pulses.
- All outputs are registered, and all pulses are exactly one cycle wide.
- `press_count` wraps 255 → 0 silently.

## Timing
- Reset (`rst_n`=0 at a `clk` edge):
  - State goes to IDLE.
  - `btn_level`, `press`, `release`, `long_press` ← 0; `press_count` ← 0.
  - `cnt`, `held`, `long_done` ← 0; synchroniser flops ← inactive level.
- Reset mid-press: the block returns to IDLE with no `release` pulse. If the button is still held after `rst_n` rises, the block re-qualifies it and emits a fresh `press`.
- Press latency: the pin goes active before edge 1 and stays clean.
  - `act` is visible after edge 2; IDLE→DB_DOWN at edge 3.
  - `press` and `btn_level` rise after edge `DEBOUNCE_CYCLES`+3.
- Release latency is symmetric: `release` pulses and `btn_level` falls `DEBOUNCE_CYCLES`+3 edges after the pin goes inactive.
- `long_press` rises `LONG_CYCLES` edges after `press` rises, counting only cycles spent in DOWN.
- Any glitch shorter than `DEBOUNCE_CYCLES` samples produces no event.
- Simultaneous events: `press` and `release` can never be high in the same cycle. `long_press` can never coincide with `press`.

## Structure
- Shared package/include `button_pkg`:
  - state encodings IDLE, DB_DOWN, DOWN, DB_UP (2 bits);
  - `HFOSC_HZ` = 48000000;
  - helper constants for ms-to-cycle conversion.
- Sub-module `sync_2ff`: parameterised reset value, reused for every asynchronous board input.
- No other hierarchy.

## Test plan
Unless stated, tests use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=10, `ACTIVE_LOW`=1.
- Reset: hold `rst_n`=0 for 3 edges with `btn_in` toggling → all outputs 0, `press_count`=0.
- Clean press: drive `btn_in` 1→0 before edge 1 and hold → `press` high only after edge 7, `btn_level`=1 from edge 7, `press_count`=1.
- Bounce rejection: pulses of 0 lasting 1, 2 and 3 cycles with 1 between them → no `press`, `btn_level` stays 0. A following 4-cycle-plus hold → exactly one `press`.
- Long press: hold for 20 cycles after `press` → one `long_press` exactly 10 edges after `press`, and none afterwards. Release → `release` pulse 7 edges after the pin returns to 1.
- Release bounce: during DB_UP, pin returns to 0 for 1 cycle → no `release`, `long_done` preserved, no second `long_press`.
- Wrap and reset mid-press:
  - 256 clean presses → `press_count` goes 255→0.
  - Assert `rst_n`=0 while in DOWN → no `release` is emitted.
  - Button still held when `rst_n` rises → a new `press` 7 edges after the release of reset.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for board push-button conditioning: FSM state encoding
// and HFOSC-based millisecond-to-cycle conversion.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DB_DOWN = 2'd1,
        DOWN    = 2'd2,
        DB_UP   = 2'd3
    } state_e;

    localparam int HFOSC_HZ      = 48000000;
    localparam int CYCLES_PER_MS = HFOSC_HZ / 1000;

    function automatic int ms_to_cycles(input int ms);
        return ms * CYCLES_PER_MS;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; RESET_VAL sets the
// level both flops take during reset (normally the pin's inactive level).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit level, press,
// release and long-press events plus a wrapping press counter.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(10),
    parameter int LONG_CYCLES     = ms_to_cycles(1000),
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press,
    output logic       release_pulse,   // "release" is a reserved word in SystemVerilog
    output logic       long_press,
    output logic [7:0] press_count
);

    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic             PIN_IDLE  = logic'(ACTIVE_LOW);

    logic pin_sync;
    logic act;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] held_q, held_d;
    logic             long_done_q, long_done_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic [7:0]       count_q, count_d;

    sync_2ff #(
        .RESET_VAL (PIN_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (pin_sync)
    );

    assign act = pin_sync ^ PIN_IDLE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        held_d      = held_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        count_d     = count_q;

        case (state_q)
            IDLE: begin
                if (act) begin
                    state_d = DB_DOWN;
                    cnt_d   = '0;
                end
            end
            DB_DOWN: begin
                if (!act) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    count_d = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DOWN: begin
                // Hold count saturates at LONG_LAST so it can be parked and resumed.
                if (!act) begin
                    state_d = DB_UP;
                    held_d  = cnt_q;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    if (!long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DB_UP: begin
                if (act) begin
                    state_d = DOWN;
                    cnt_d   = held_q;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            long_done_d = 1'b0;
        end
        level_d = (state_d == DOWN) || (state_d == DB_UP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            held_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            held_q      <= held_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            count_q     <= count_d;
        end
    end

    assign btn_level     = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Randomised and directed bench for button_debounce against a run-length
// reference model of the debounce and hold-time rules.
module tb_button_debounce;

    localparam int DEB = 4;
    localparam int LNG = 10;

    logic       clk;
    logic       rst_n;
    logic       btn_in;
    logic       btn_level;
    logic       press;
    logic       release_pulse;
    logic       long_press;
    logic [7:0] press_count;
    logic [11:0] obs;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0] m_hist;
    logic       m_level;
    logic       m_prev_act;
    logic       m_long_fired;
    logic [7:0] m_count;
    int         m_run;
    int         m_held;
    logic       e_press, e_rel, e_long;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .press_count   (press_count)
    );

    assign obs = {btn_level, press, release_pulse, long_press, press_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] exp_vec();
        return {m_level, e_press, e_rel, e_long, m_count};
    endfunction

    // Drive one cycle, advance the model over the same edge, sample #1 later.
    // A level change is accepted after DEB+1 consecutive opposite samples;
    // hold time counts edges spent pressed whose previous sample was also pressed.
    task automatic tick(input logic pin, input logic rstn);
        logic a;
        btn_in = pin;
        rst_n  = rstn;
        @(posedge clk);
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
        if (!rstn) begin
            m_hist       = 2'b11;
            m_level      = 1'b0;
            m_prev_act   = 1'b0;
            m_long_fired = 1'b0;
            m_count      = 8'd0;
            m_run        = 0;
            m_held       = 0;
        end else begin
            a = ~m_hist[1];
            m_hist = {m_hist[0], pin};
            if (a != m_level) m_run++;
            else m_run = 0;
            if (m_level && a && m_prev_act) begin
                m_held++;
                if (m_held == LNG && !m_long_fired) begin
                    e_long       = 1'b1;
                    m_long_fired = 1'b1;
                end
            end
            if (m_run == DEB + 1) begin
                m_level = a;
                m_run   = 0;
                if (a) begin
                    e_press      = 1'b1;
                    m_count      = m_count + 8'd1;
                    m_held       = 0;
                    m_long_fired = 1'b0;
                end else begin
                    e_rel = 1'b1;
                end
            end
            m_prev_act = a;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(logic'(i % 2), 1'b0);
            checks++;
            if (obs !== 12'h000) begin
                errors++;
                $display("FAIL reset cyc %0d: got %h want %h", i, obs, 12'h000);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        int press_edge = -1;
        int rel_edge   = -1;
        for (int e = 1; e <= 12; e++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL clean_press edge %0d: got %h want %h", e, obs, exp_vec());
            end
            if (press === 1'b1 && press_edge < 0) press_edge = e;
        end
        checks++;
        if (press_edge != DEB + 3) begin
            errors++;
            $display("FAIL press_latency: got %0d want %0d", press_edge, DEB + 3);
        end
        checks++;
        if (press_count !== 8'd1 || btn_level !== 1'b1) begin
            errors++;
            $display("FAIL press_state: got cnt %0d lvl %b want cnt 1 lvl 1", press_count, btn_level);
        end
        for (int e = 1; e <= 12; e++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL clean_release edge %0d: got %h want %h", e, obs, exp_vec());
            end
            if (release_pulse === 1'b1 && rel_edge < 0) rel_edge = e;
        end
        checks++;
        if (rel_edge != DEB + 3) begin
            errors++;
            $display("FAIL release_latency: got %0d want %0d", rel_edge, DEB + 3);
        end
    endtask

    task automatic test_bounce();
        logic [11:0] pat = 12'b0110_0110_0011;
        int presses = 0;
        for (int i = 0; i < 12; i++) begin
            tick(pat[11 - i], 1'b1);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL bounce cyc %0d: got %h want %h", i, obs, exp_vec());
            end
            if (press === 1'b1 || btn_level === 1'b1) presses++;
        end
        checks++;
        if (presses != 0) begin
            errors++;
            $display("FAIL bounce_reject: got %0d events want 0", presses);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL bounce_hold cyc %0d: got %h want %h", i, obs, exp_vec());
            end
            if (press === 1'b1) presses++;
        end
        checks++;
        if (presses != 1) begin
            errors++;
            $display("FAIL bounce_then_press: got %0d presses want 1", presses);
        end
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    endtask

    task automatic test_long_press();
        int press_edge = -1;
        int long_edge  = -1;
        int longs      = 0;
        int rel_edge   = -1;
        for (int e = 1; e <= 40; e++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL long_hold edge %0d: got %h want %h", e, obs, exp_vec());
            end
            if (press === 1'b1 && press_edge < 0) press_edge = e;
            if (long_press === 1'b1) begin
                longs++;
                if (long_edge < 0) long_edge = e;
            end
        end
        checks++;
        if (longs != 1 || long_edge - press_edge != LNG) begin
            errors++;
            $display("FAIL long_timing: got %0d pulses at +%0d want 1 at +%0d",
                     longs, long_edge - press_edge, LNG);
        end
        for (int e = 1; e <= 12; e++) begin
            tick(1'b1, 1'b1);
            if (release_pulse === 1'b1 && rel_edge < 0) rel_edge = e;
        end
        checks++;
        if (rel_edge != DEB + 3) begin
            errors++;
            $display("FAIL long_release: got %0d want %0d", rel_edge, DEB + 3);
        end
    endtask

    task automatic test_release_bounce();
        logic [17:0] pat = 18'b11_0_000000000000000;
        int rels  = 0;
        int longs = 0;
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 18; i++) begin
            tick(pat[17 - i], 1'b1);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL rel_bounce cyc %0d: got %h want %h", i, obs, exp_vec());
            end
            if (release_pulse === 1'b1) rels++;
            if (long_press === 1'b1) longs++;
        end
        checks++;
        if (rels != 0 || longs != 0 || btn_level !== 1'b1) begin
            errors++;
            $display("FAIL rel_bounce_events: got rel %0d long %0d lvl %b want 0 0 1", rels, longs, btn_level);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b1);
            if (release_pulse === 1'b1) rels++;
        end
        checks++;
        if (rels != 1) begin
            errors++;
            $display("FAIL rel_after_bounce: got %0d releases want 1", rels);
        end
    endtask

    task automatic test_wrap();
        logic saw_255 = 1'b0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 16; i++) begin
                tick(i < 8 ? 1'b0 : 1'b1, 1'b1);
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL wrap press %0d cyc %0d: got %h want %h", p, i, obs, exp_vec());
                end
                if (press_count === 8'd255) saw_255 = 1'b1;
            end
        end
        checks++;
        if (press_count !== 8'd0 || saw_255 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_count: got %0d saw255 %b want 0 1", press_count, saw_255);
        end
    endtask

    task automatic test_reset_mid_press();
        int rels = 0;
        int press_edge = -1;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0);
            if (release_pulse === 1'b1) rels++;
        end
        for (int e = 1; e <= 12; e++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL mid_reset edge %0d: got %h want %h", e, obs, exp_vec());
            end
            if (release_pulse === 1'b1) rels++;
            if (press === 1'b1 && press_edge < 0) press_edge = e;
        end
        checks++;
        if (rels != 0 || press_edge != DEB + 3) begin
            errors++;
            $display("FAIL mid_reset_events: got rel %0d press@%0d want 0 and %0d", rels, press_edge, DEB + 3);
        end
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int b = 0; b < 150; b++) begin
            logic pin = logic'($urandom_range(0, 1));
            int len   = int'($urandom_range(1, 16));
            logic rb  = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < len; i++) begin
                tick(pin, !(rb && i == 0));
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL random burst %0d cyc %0d: got %h want %h", b, i, obs, exp_vec());
                end
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        btn_in = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_release_bounce();
        test_wrap();
        test_reset_mid_press();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
